shift_logic_unit_mc: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle RV32 logic/shift unit. Bitwise ops complete in one cycle. Shifts and rotates run iteratively, STEP bit positions per cycle, so the block trades latency for area and timing. It sits in the execute stage behind a valid/ready handshake on both sides, so the pipeline can stall it, and it can stall the pipeline.

---
 rtl/shift_logic_unit_mc.sv | 163 ++++++++++++++++
 tb/tb_shift_logic_unit_mc.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_logic_unit_mc.sv
// Logic/shift unit with an iterative shifter (STEP bits per cycle); ZBB_LOGIC_EN adds ANDN/ORN/XNOR/ROL/ROR.
// Latency: 1 cycle for bitwise/unknown/shamt==0, 1+ceil(shamt/STEP) cycles for shifts and rotates.
// Backpressure: result held in DONE until i_ready; o_ready is low while shifting or while a result is unconsumed.
module shift_logic_unit_mc #(
  parameter int XLEN = 32,
  parameter int STEP = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_data_a,
  input  logic [XLEN-1:0] i_data_b,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_data,
  output logic            o_busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
`ifdef ZBB_LOGIC_EN
  localparam logic [3:0] OP_ANDN = 4'd6;
  localparam logic [3:0] OP_ORN  = 4'd7;
  localparam logic [3:0] OP_XNOR = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [SHW:0] XLEN_W = (SHW+1)'(XLEN);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q;
  logic [XLEN-1:0] acc_q;
  logic [SHW-1:0]  rem_q;

  logic            accept;
  logic            start_shift;
  logic            is_shift;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] imm_res;
  logic [SHW:0]    rem_ext;
  logic [SHW:0]    step_ext;
  logic [SHW-1:0]  step;
  logic            last_step;
  logic [XLEN-1:0] step_res;
`ifdef ZBB_LOGIC_EN
  logic [SHW:0]    rot_inv;
`endif

  assign shamt       = i_data_b[SHW-1:0];
  assign o_ready     = (state_q == S_IDLE) | ((state_q == S_DONE) & i_ready);
  assign accept      = i_valid & o_ready & ~i_flush;
  assign start_shift = accept & is_shift & (shamt != '0);
  assign o_valid     = (state_q == S_DONE);
  assign o_busy      = (state_q == S_SHIFT);

  // Single-cycle result; for shift ops this is only used when shamt==0.
  always_comb begin
    imm_res  = '0;
    is_shift = 1'b0;
    case (i_op)
      OP_AND:  imm_res = i_data_a & i_data_b;
      OP_OR:   imm_res = i_data_a | i_data_b;
      OP_XOR:  imm_res = i_data_a ^ i_data_b;
      OP_SLL, OP_SRL, OP_SRA: begin
        imm_res  = i_data_a;
        is_shift = 1'b1;
      end
`ifdef ZBB_LOGIC_EN
      OP_ANDN: imm_res = i_data_a & ~i_data_b;
      OP_ORN:  imm_res = i_data_a | ~i_data_b;
      OP_XNOR: imm_res = ~(i_data_a ^ i_data_b);
      OP_ROL, OP_ROR: begin
        imm_res  = i_data_a;
        is_shift = 1'b1;
      end
`endif
      default: imm_res = '0;
    endcase
  end

  assign rem_ext   = {1'b0, rem_q};
  assign step_ext  = (rem_ext > STEP_W) ? STEP_W : rem_ext;
  assign step      = step_ext[SHW-1:0];
  assign last_step = (rem_q == step);
`ifdef ZBB_LOGIC_EN
  assign rot_inv   = XLEN_W - {1'b0, step};
`endif

  // step is never zero in SHIFT, so rot_inv stays below XLEN.
  always_comb begin
    step_res = acc_q;
    case (op_q)
      OP_SLL:  step_res = acc_q << step;
      OP_SRL:  step_res = acc_q >> step;
      OP_SRA:  step_res = $signed(acc_q) >>> step;
`ifdef ZBB_LOGIC_EN
      OP_ROL:  step_res = (acc_q << step) | (acc_q >> rot_inv);
      OP_ROR:  step_res = (acc_q >> step) | (acc_q << rot_inv);
`endif
      default: step_res = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = start_shift ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        if (accept)       state_d = start_shift ? S_SHIFT : S_DONE;
        else if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_flush) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q   <= '0;
      acc_q  <= '0;
      rem_q  <= '0;
      o_data <= '0;
    end else if (i_flush) begin
      rem_q <= '0;
    end else if (accept) begin
      op_q  <= i_op;
      acc_q <= i_data_a;
      rem_q <= shamt;
      if (!start_shift) o_data <= imm_res;
    end else if (state_q == S_SHIFT) begin
      acc_q <= step_res;
      rem_q <= rem_q - step;
      if (last_step) o_data <= step_res;
    end
  end

endmodule

// File: tb/tb_shift_logic_unit_mc.sv
// Bench for shift_logic_unit_mc: directed literal cases plus random traffic against a cycle-count reference model.
module tb_shift_logic_unit_mc;

  localparam int XLEN = 32;
  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  op;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model state: pending cycles until result, current output view.
  bit          m_valid = 1'b0;
  int          m_wait  = 0;
  logic [31:0] m_data  = '0;
  logic [31:0] m_pend  = '0;

  shift_logic_unit_mc #(.XLEN(XLEN), .STEP(STEP)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_flush  (flush),
    .i_valid  (in_valid),
    .o_ready  (out_ready),
    .i_op     (op),
    .i_data_a (data_a),
    .i_data_b (data_b),
    .o_valid  (out_valid),
    .i_ready  (in_ready),
    .o_data   (out_data),
    .o_busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_shift_op(input logic [3:0] o);
`ifdef ZBB_LOGIC_EN
    return (o inside {4'd3, 4'd4, 4'd5, 4'd9, 4'd10});
`else
    return (o inside {4'd3, 4'd4, 4'd5});
`endif
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (o)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a ^ b;
      4'd3: return a << sh;
      4'd4: return a >> sh;
      4'd5: return $signed(a) >>> sh;
`ifdef ZBB_LOGIC_EN
      4'd6: return a & ~b;
      4'd7: return a | ~b;
      4'd8: return ~(a ^ b);
      4'd9: return (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
      4'd10: return (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] o, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (is_shift_op(o) && sh > 0) return 1 + (sh + STEP - 1) / STEP;
    return 1;
  endfunction

  task automatic model_step();
    bit rdy;
    int lat;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_wait  = 0;
      m_data  = '0;
    end else begin
      rdy = (m_wait == 0) && (!m_valid || in_ready);
      if (flush) begin
        m_valid = 1'b0;
        m_wait  = 0;
      end else if (in_valid && rdy) begin
        lat = ref_lat(op, data_b);
        if (lat == 1) begin
          m_valid = 1'b1;
          m_data  = ref_res(op, data_a, data_b);
        end else begin
          m_valid = 1'b0;
          m_wait  = lat - 1;
          m_pend  = ref_res(op, data_a, data_b);
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1;
          m_data  = m_pend;
        end
      end else if (m_valid && in_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cyc_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("cyc_busy",  {31'b0, busy},      {31'b0, m_wait > 0});
      chk("cyc_ready", {31'b0, out_ready}, {31'b0, (m_wait == 0) && (!m_valid || in_ready)});
      chk("cyc_data",  out_data, m_data);
    end
  end

  // Starts and ends just after a rising edge; returns after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    op = o;
    data_a = a;
    data_b = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_ready) got = 1'b1;
      @(posedge clk);
      #1;
      if (got) break;
    end
    if (!got) chk("accept_timeout", 32'h0, 32'h1);
    in_valid = 1'b0;
    op = 4'($urandom);
    data_a = $urandom;
    data_b = $urandom;
  endtask

  task automatic wait_valid(output int lat, output int busy_n);
    bit seen;
    seen = 1'b0;
    lat = 0;
    busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
    end
    if (!seen) chk("valid_timeout", 32'h0, 32'h1);
  endtask

  task automatic run(input string name, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, busy_n;
    send(o, a, b);
    wait_valid(lat, busy_n);
    chk({name, "_data"}, out_data, exp);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, busy_n;
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_ready = 1'b1;
    op = '0;
    data_a = '0;
    data_b = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_busy",  {31'b0, busy},      32'h0);
    chk("rst_data",  out_data,           32'h0);
    chk("rst_ready", {31'b0, out_ready}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // AND with result held under backpressure.
    in_ready = 1'b0;
    send(4'd0, 32'hF0F0F0F0, 32'h0FF00FF0);
    wait_valid(lat, busy_n);
    chk("and_data", out_data, 32'h00F000F0);
    chk("and_lat", 32'(lat), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, out_valid}, 32'h1);
      chk("hold_data", out_data, 32'h00F000F0);
    end
    @(posedge clk);
    #1 in_ready = 1'b1;
    @(posedge clk);
    #1;

    run("sll20",   4'd3, 32'h00000001, 32'd20,       32'h00100000, 4);
    run("sra31",   4'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
    run("srl31",   4'd4, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 5);
    run("sll_hib", 4'd3, 32'h00000003, 32'h00000124, 32'h00000030, 2);
    run("sll0",    4'd3, 32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF, 1);
    run("unk",     4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1);
`ifdef ZBB_LOGIC_EN
    run("ror8",  4'd10, 32'h12345678, 32'd8, 32'h78123456, 2);
    run("rol1",  4'd9,  32'h80000001, 32'd1, 32'h00000003, 2);
    run("ror0",  4'd10, 32'h12345678, 32'd0, 32'h12345678, 1);
    run("andn",  4'd6,  32'hFF00FF00, 32'h0F0F0F0F, 32'hF000F000, 1);
`else
    run("ror8",  4'd10, 32'h12345678, 32'd8, 32'h00000000, 1);
    run("rol1",  4'd9,  32'h80000001, 32'd1, 32'h00000000, 1);
    run("andn",  4'd6,  32'hFF00FF00, 32'h0F0F0F0F, 32'h00000000, 1);
`endif

    // Back-to-back: XOR result consumed on the same edge the SLL is accepted.
    in_ready = 1'b0;
    send(4'd2, 32'hA5A5A5A5, 32'h0F0F0F0F);
    wait_valid(lat, busy_n);
    chk("b2b_xor_data", out_data, 32'hAAAAAAAA);
    @(posedge clk);
    #1 in_ready = 1'b1;
    send(4'd3, 32'h00000001, 32'd4);
    wait_valid(lat, busy_n);
    chk("b2b_sll_data", out_data, 32'h00000010);
    chk("b2b_sll_lat", 32'(lat), 32'd2);
    chk("b2b_no_gap", 32'(busy_n), 32'd1);
    @(posedge clk);
    #1;

    // Flush during the second SHIFT cycle.
    send(4'd3, 32'h00000001, 32'd24);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_ready", {31'b0, out_ready}, 32'h1);
    chk("flush_busy",  {31'b0, busy},      32'h0);
    repeat (4) begin
      chk("flush_valid", {31'b0, out_valid}, 32'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // Reset mid-SHIFT.
    send(4'd3, 32'h00000001, 32'd24);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", {31'b0, out_valid}, 32'h0);
    chk("rstmid_busy",  {31'b0, busy},      32'h0);
    chk("rstmid_data",  out_data,           32'h0);
    chk("rstmid_ready", {31'b0, out_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rstmid_no_valid", {31'b0, out_valid}, 32'h0);
    end
    @(posedge clk);
    #1;

    // Random traffic; inputs change every cycle, so latching is exercised too.
    for (int i = 0; i < 4000; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      op       = 4'($urandom_range(0, 15));
      data_a   = $urandom;
      data_b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      in_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 40) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    flush = 1'b0;
    in_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
